pad_io_ctrl: RTL and testbench

PAD_IO_CTRL -- requirements
Module: pad_io_ctrl

---
 rtl/pad_io_pkg.sv | 29 ++
 rtl/pad_io_if.sv | 43 ++++
 rtl/pad_io_chan.sv | 99 +++++++++
 rtl/pad_io_ctrl.sv | 68 ++++++
 tb/tb_pad_io_ctrl.sv | 241 ++++++++++++++++++++++++
 5 files changed

// File: rtl/pad_io_pkg.sv
// pad_io_pkg -- shared constants and helpers for the GPIO pad controller.
//
// Contents:
//   N_CH_DEF, SYNC_STAGES_DEF, DB_CYCLES_DEF : default parameter values
//   clog2_f()                                : ceil(log2(v)), usable in constant expressions
//   cnt_width_f()                            : debounce counter width, clog2(max(db,2))
//
// Configuration macro: PAD_IO_DEBOUNCE_EN (consumed by pad_io_chan).
package pad_io_pkg;

   localparam int N_CH_DEF        = 16;
   localparam int SYNC_STAGES_DEF = 2;
   localparam int DB_CYCLES_DEF   = 1024;

   function automatic int clog2_f(input int v);
      int r;
      r = 0;
      for (int i = 0; i < 31; i++) begin
         if ((1 << i) < v) r = i + 1;
      end
      return r;
   endfunction

   // A 1-bit counter is the minimum, so DB_CYCLES of 1 still gets a legal width.
   function automatic int cnt_width_f(input int db);
      return clog2_f((db < 2) ? 2 : db);
   endfunction

endpackage

// File: rtl/pad_io_if.sv
// pad_io_if -- bundle of the GPIO-peripheral side and the iobuf side signals.
//
// Signals (all N_CH wide unless noted):
//   IO_OUT, IO_OP_EN          peripheral -> controller, output data / enable
//   IO_IN                     controller -> peripheral, debounced pad level
//   PAD_C                     iobuf -> controller, raw asynchronous pad level
//   PAD_I, PAD_OEN            controller -> iobuf, data and active-low enable
//   IRQ_RISE_EN, IRQ_FALL_EN  per-channel edge interrupt enables
//   IRQ_CLR                   per-channel single-cycle status clear strobe
//   IRQ_STATUS, IRQ (1 bit)   sticky edge status and its OR
//
// Modports: master = peripheral/pad environment, slave = pad_io_ctrl.
//
// There is no valid/ready handshake on this bundle: every signal is a level
// that is sampled or driven on each rising CLK edge, and IRQ_CLR acts on
// exactly the edge where it is seen high.
interface pad_io_if
   import pad_io_pkg::*;
   #(parameter int N_CH = N_CH_DEF);

   logic [N_CH-1:0] IO_OUT;
   logic [N_CH-1:0] IO_OP_EN;
   logic [N_CH-1:0] IO_IN;
   logic [N_CH-1:0] PAD_C;
   logic [N_CH-1:0] PAD_I;
   logic [N_CH-1:0] PAD_OEN;
   logic [N_CH-1:0] IRQ_RISE_EN;
   logic [N_CH-1:0] IRQ_FALL_EN;
   logic [N_CH-1:0] IRQ_CLR;
   logic [N_CH-1:0] IRQ_STATUS;
   logic            IRQ;

   modport master (
      output IO_OUT, IO_OP_EN, PAD_C, IRQ_RISE_EN, IRQ_FALL_EN, IRQ_CLR,
      input  IO_IN, PAD_I, PAD_OEN, IRQ_STATUS, IRQ
   );

   modport slave (
      input  IO_OUT, IO_OP_EN, PAD_C, IRQ_RISE_EN, IRQ_FALL_EN, IRQ_CLR,
      output IO_IN, PAD_I, PAD_OEN, IRQ_STATUS, IRQ
   );

endinterface

// File: rtl/pad_io_chan.sv
// pad_io_chan -- one GPIO input channel: synchroniser, debounce, edge detect
// and sticky interrupt status.
//
// Ports:
//   clk_i, rst_i   clock, asynchronous active-high reset
//   pad_c_i        raw pad level (asynchronous to clk_i)
//   rise_en_i      set status when the debounced level goes 0->1
//   fall_en_i      set status when the debounced level goes 1->0
//   clr_i          clear status (a coincident set wins)
//   io_in_o        debounced level
//   status_o       sticky edge status
//
// Configuration macro PAD_IO_DEBOUNCE_EN: when defined the synchronised level
// must differ from the stable level for DB_CYCLES consecutive edges before it
// is accepted; when undefined the stable level follows the synchroniser output
// one edge later and no counter is built.
module pad_io_chan
   import pad_io_pkg::*;
   #(
   parameter int SYNC_STAGES = SYNC_STAGES_DEF
`ifdef PAD_IO_DEBOUNCE_EN
   ,
   parameter int DB_CYCLES   = DB_CYCLES_DEF
`endif
   ) (
   input  logic clk_i,
   input  logic rst_i,
   input  logic pad_c_i,
   input  logic rise_en_i,
   input  logic fall_en_i,
   input  logic clr_i,
   output logic io_in_o,
   output logic status_o
);

   logic [SYNC_STAGES-1:0] sync_q, sync_d;
   logic                   s_w;
   logic                   stable_q, stable_d;
   logic                   status_q, status_d;
   logic                   set_w;

   assign sync_d = {sync_q[SYNC_STAGES-2:0], pad_c_i};
   assign s_w    = sync_q[SYNC_STAGES-1];

`ifdef PAD_IO_DEBOUNCE_EN
   localparam int                CNT_W   = cnt_width_f(DB_CYCLES);
   localparam logic [CNT_W-1:0]  CNT_MAX = CNT_W'(DB_CYCLES - 1);

   logic [CNT_W-1:0] cnt_q, cnt_d;

   // Any return of s to the stable level restarts qualification from zero.
   always_comb begin
      stable_d = stable_q;
      cnt_d    = cnt_q;
      if (s_w == stable_q) begin
         cnt_d = '0;
      end else if (cnt_q == CNT_MAX) begin
         stable_d = s_w;
         cnt_d    = '0;
      end else begin
         cnt_d = cnt_q + 1'b1;
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end
`else
   always_comb begin
      stable_d = s_w;
   end
`endif

   // Edge is judged on the transition being committed this edge, so status
   // rises on the same edge as io_in_o.
   assign set_w    = (stable_d & ~stable_q & rise_en_i) |
                     (~stable_d & stable_q & fall_en_i);
   assign status_d = set_w | (status_q & ~clr_i);

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         sync_q   <= '0;
         stable_q <= 1'b0;
         status_q <= 1'b0;
      end else begin
         sync_q   <= sync_d;
         stable_q <= stable_d;
         status_q <= status_d;
      end
   end

   assign io_in_o  = stable_q;
   assign status_o = status_q;

endmodule

// File: rtl/pad_io_ctrl.sv
// pad_io_ctrl -- GPIO pad controller: registered output path to the iobufs
// and N_CH independent input channels with debounce and edge interrupts.
//
// Ports:
//   CLK      system clock, all registers on its rising edge
//   RESET    asynchronous active-high reset (pads hi-Z, status cleared)
//   pad_io   pad_io_if.slave bundle (see rtl/pad_io_if.sv)
//
// Parameters: N_CH (1..32), SYNC_STAGES (2..4), DB_CYCLES (1..65535).
// Configuration macro PAD_IO_DEBOUNCE_EN selects the debounced input path;
// without it DB_CYCLES has no effect.
module pad_io_ctrl
   import pad_io_pkg::*;
   #(
   parameter int N_CH        = N_CH_DEF,
   parameter int SYNC_STAGES = SYNC_STAGES_DEF,
   parameter int DB_CYCLES   = DB_CYCLES_DEF
   ) (
   input  logic    CLK,
   input  logic    RESET,
   pad_io_if.slave pad_io
);

   logic [N_CH-1:0] pad_i_q, pad_i_d;
   logic [N_CH-1:0] pad_oen_q, pad_oen_d;
   logic [N_CH-1:0] io_in_w;
   logic [N_CH-1:0] status_w;

   assign pad_i_d   = pad_io.IO_OUT;
   assign pad_oen_d = ~pad_io.IO_OP_EN;

   // Reset releases every pad to hi-Z with a defined zero on its data pin.
   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) begin
         pad_i_q   <= '0;
         pad_oen_q <= '1;
      end else begin
         pad_i_q   <= pad_i_d;
         pad_oen_q <= pad_oen_d;
      end
   end

   for (genvar c = 0; c < N_CH; c++) begin : g_chan
      pad_io_chan #(
         .SYNC_STAGES (SYNC_STAGES)
`ifdef PAD_IO_DEBOUNCE_EN
         ,
         .DB_CYCLES   (DB_CYCLES)
`endif
      ) u_chan (
         .clk_i     (CLK),
         .rst_i     (RESET),
         .pad_c_i   (pad_io.PAD_C[c]),
         .rise_en_i (pad_io.IRQ_RISE_EN[c]),
         .fall_en_i (pad_io.IRQ_FALL_EN[c]),
         .clr_i     (pad_io.IRQ_CLR[c]),
         .io_in_o   (io_in_w[c]),
         .status_o  (status_w[c])
      );
   end

   assign pad_io.PAD_I      = pad_i_q;
   assign pad_io.PAD_OEN    = pad_oen_q;
   assign pad_io.IO_IN      = io_in_w;
   assign pad_io.IRQ_STATUS = status_w;
   assign pad_io.IRQ        = |status_w;

endmodule

// File: tb/tb_pad_io_ctrl.sv
// tb_pad_io_ctrl -- self-checking bench for pad_io_ctrl (N_CH=16,
// SYNC_STAGES=2, DB_CYCLES=4). Expected outputs come from a pad-history
// reference model; a monitor compares them on every falling clock edge.
// Follows PAD_IO_DEBOUNCE_EN the same way the design does.
module tb_pad_io_ctrl;

   localparam int N  = 16;
   localparam int SY = 2;
   localparam int DB = 4;
`ifdef PAD_IO_DEBOUNCE_EN
   localparam int DBE = DB;
`else
   localparam int DBE = 1;
`endif
   // Edges from the first sampling edge to the IO_IN change.
   localparam int LAT = SY + DBE;
   localparam int W   = 4 * N + 1;

   // ---------------- clock / reset ----------------
   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   logic [N-1:0] io_out  = '0;
   logic [N-1:0] op_en   = '0;
   logic [N-1:0] pad_c   = '0;
   logic [N-1:0] rise_en = '0;
   logic [N-1:0] fall_en = '0;
   logic [N-1:0] clr     = '0;

   pad_io_if #(.N_CH(N)) bus ();

   assign bus.IO_OUT      = io_out;
   assign bus.IO_OP_EN    = op_en;
   assign bus.PAD_C       = pad_c;
   assign bus.IRQ_RISE_EN = rise_en;
   assign bus.IRQ_FALL_EN = fall_en;
   assign bus.IRQ_CLR     = clr;

   pad_io_ctrl #(.N_CH(N), .SYNC_STAGES(SY), .DB_CYCLES(DB)) dut (
      .CLK    (clk),
      .RESET  (rst),
      .pad_io (bus)
   );

   // ---------------- scoreboard ----------------
   int total = 0;
   int bad   = 0;
   logic [W-1:0] exp_q[$];

   function automatic void check(string name, logic [31:0] act, logic [31:0] want);
      total++;
      if (act !== want) begin
         bad++;
         $display("FAIL %s: got %h want %h at %0t", name, act, want, $time);
      end
   endfunction

   // ---------------- reference model ----------------
   // m_hist holds the pad levels sampled on the last LAT edges (oldest first).
   // A channel's level is accepted once the DBE oldest of those, which are the
   // values the synchroniser has delivered on the last DBE edges, all agree
   // and differ from the current level.
   logic [N-1:0] m_hist[$];
   logic [N-1:0] m_stable, m_status, m_pad_i, m_pad_oen;

   function automatic void model_reset();
      m_hist.delete();
      for (int k = 0; k < LAT; k++) m_hist.push_back('0);
      m_stable  = '0;
      m_status  = '0;
      m_pad_i   = '0;
      m_pad_oen = '1;
   endfunction

   function automatic void model_edge();
      logic [N-1:0] nxt;
      logic [N-1:0] rise;
      logic [N-1:0] fall;
      m_hist.push_back(pad_c);
      if (m_hist.size() > LAT) void'(m_hist.pop_front());
      nxt = m_stable;
      for (int c = 0; c < N; c++) begin
         logic v;
         logic same;
         v    = m_hist[0][c];
         same = 1'b1;
         for (int k = 1; k < DBE; k++) if (m_hist[k][c] != v) same = 1'b0;
         if (same && (v != m_stable[c])) nxt[c] = v;
      end
      rise      = nxt & ~m_stable & rise_en;
      fall      = ~nxt & m_stable & fall_en;
      m_status  = (m_status & ~clr) | rise | fall;
      m_stable  = nxt;
      m_pad_i   = io_out;
      m_pad_oen = ~op_en;
   endfunction

   // ---------------- driver tasks ----------------
   // Called at posedge+1: queue what the outputs must show until the next
   // edge, then let that edge happen and advance the model.
   task automatic step();
      if (rst) model_reset();
      exp_q.push_back({m_pad_i, m_pad_oen, m_stable, m_status, |m_status});
      @(posedge clk);
      if (!rst) model_edge();
      #1;
   endtask

   task automatic measure(input int ch, output int lat);
      lat = 99;
      for (int i = 1; i <= 20; i++) begin
         step();
         if (bus.IO_IN[ch] === 1'b1) begin
            lat = i;
            break;
         end
      end
   endtask

   // ---------------- monitor ----------------
   initial begin
      logic [W-1:0] e;
      forever begin
         @(negedge clk);
         if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check("pad_i",      32'(bus.PAD_I),      32'(e[4*N:3*N+1]));
            check("pad_oen",    32'(bus.PAD_OEN),    32'(e[3*N:2*N+1]));
            check("io_in",      32'(bus.IO_IN),      32'(e[2*N:N+1]));
            check("irq_status", 32'(bus.IRQ_STATUS), 32'(e[N:1]));
            check("irq",        32'(bus.IRQ),        32'(e[0]));
         end
      end
   end

   // ---------------- stimulus ----------------
   initial begin
      int lat;
      model_reset();
      io_out = 16'hA5A5;
      op_en  = 16'hFFFF;
      @(posedge clk);
      #1;
      repeat (3) step();
      check("oen_in_reset", 32'(bus.PAD_OEN), 32'h0000_FFFF);

      // Output path: one edge after release.
      rst = 1'b0;
      step();
      check("oen_release",   32'(bus.PAD_OEN), 32'h0000_0000);
      check("pad_i_release", 32'(bus.PAD_I),   32'h0000_A5A5);
      repeat (2) step();

      // Rising edge on channel 3.
      rise_en  = 16'h00A8;
      pad_c[3] = 1'b1;
      measure(3, lat);
      check("lat_rise3",  32'(lat),            32'(LAT));
      check("status_r3",  32'(bus.IRQ_STATUS), 32'h0000_0008);
      check("irq_r3",     32'(bus.IRQ),        32'h1);
      clr[3] = 1'b1;
      step();
      clr = '0;
      repeat (2) step();

      // Short pulse on channel 5.
      pad_c[5] = 1'b1;
      repeat (3) step();
      pad_c[5] = 1'b0;
      repeat (10) step();

      // Falling edge on channel 3 with a coincident clear: set wins.
      fall_en[3] = 1'b1;
      pad_c[3]   = 1'b0;
      repeat (LAT - 1) step();
      clr[3] = 1'b1;
      step();
      clr = '0;
      check("set_wins3", 32'(bus.IRQ_STATUS[3]), 32'h1);
      check("io_fall3",  32'(bus.IO_IN[3]),      32'h0);
      step();
      clr[3] = 1'b1;
      step();
      clr = '0;
      check("clr3", 32'(bus.IRQ_STATUS[3]), 32'h0);

      // Reset in the middle of qualification on channel 7.
      pad_c[7] = 1'b1;
      repeat (SY + 2) step();
      rst = 1'b1;
      step();
      check("io7_in_reset", 32'(bus.IO_IN[7]), 32'h0);
      step();
      rst = 1'b0;
      measure(7, lat);
      check("lat_rst7",   32'(lat),               32'(LAT));
      check("status_r7",  32'(bus.IRQ_STATUS[7]), 32'h1);
      repeat (3) step();

      // Single-cycle pulse on channel 0.
      rise_en[0] = 1'b1;
      pad_c[0]   = 1'b1;
      step();
      pad_c[0] = 1'b0;
      repeat (8) step();

      // Randomised traffic on all channels at once.
      rise_en = 16'($urandom);
      fall_en = 16'($urandom);
      for (int i = 0; i < 400; i++) begin
         if ($urandom_range(0, 7) == 0) pad_c = pad_c ^ 16'($urandom & $urandom);
         if ($urandom_range(0, 2) == 0) pad_c = pad_c ^ 16'($urandom & $urandom & $urandom);
         clr    = ($urandom_range(0, 5) == 0) ? 16'($urandom) : '0;
         io_out = 16'($urandom);
         op_en  = 16'($urandom);
         if ($urandom_range(0, 40) == 0) begin
            rise_en = 16'($urandom);
            fall_en = 16'($urandom);
         end
         rst = ($urandom_range(0, 150) == 0);
         step();
      end
      rst = 1'b0;
      clr = '0;
      repeat (10) step();

      @(negedge clk);
      #1;
      check("drain", 32'(exp_q.size()), 32'h0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout want finish");
      $fatal(1);
   end

endmodule
